// File: rtl/matmul_result_drain.sv
// rtl/matmul_result_drain.sv - snapshot, requantize and stream the systolic matmul result
//
// Captures the post-ReLU DIM x DIM product array on mm_done. It then streams the
// valid m x p sub-block row-major, one requantized element per accepted beat.
//
// Optional build macro: MATMUL_DRAIN_ROUND_EN
//   defined   : round-half-up before the right shift (widened adder, no wrap)
//   undefined : plain truncating shift
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   mm_done      one-cycle pulse from the multiplier: mm_data is final
//   m, p         valid rows / columns of the result, clamped to DIM
//   shift        requantization right-shift amount
//   mm_data      DIM x DIM array of unsigned 2*BITS products
//   out_valid    out_data holds a valid element
//   out_ready    consumer accepts the element this cycle
//   out_data     requantized, saturated element
//   out_row      row index of out_data
//   out_col      column index of out_data
//   out_last     final element of the block
//   busy         capture or stream in progress
//   drain_done   one-cycle pulse after the block has fully drained
//   overrun      sticky: mm_done arrived while the block was not idle

module matmul_result_drain #(
   parameter int BITS = 8,
   parameter int DIM  = 32,
   parameter int SHW  = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 mm_done,
   input  logic [$clog2(DIM):0]                 m,
   input  logic [$clog2(DIM):0]                 p,
   input  logic [SHW-1:0]                       shift,
   input  logic [DIM-1:0][DIM-1:0][2*BITS-1:0]  mm_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [BITS-1:0]                      out_data,
   output logic [$clog2(DIM)-1:0]               out_row,
   output logic [$clog2(DIM)-1:0]               out_col,
   output logic                                 out_last,
   output logic                                 busy,
   output logic                                 drain_done,
   output logic                                 overrun
);

   localparam int IW = $clog2(DIM);
   localparam int MW = IW + 1;
   localparam int EW = 2 * BITS;
   localparam int WW = EW + 1;
   localparam logic [MW-1:0] DIM_M = MW'(DIM);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_STREAM  = 2'd2;
   localparam logic [1:0] S_FINISH  = 2'd3;

   logic [1:0]                      state;
   logic [DIM-1:0][DIM-1:0][EW-1:0] cap_mem;
   logic [MW-1:0]                   m_lat;
   logic [MW-1:0]                   p_lat;
   logic [SHW-1:0]                  shift_lat;
   logic [IW-1:0]                   row;
   logic [IW-1:0]                   col;

   logic                            start;
   logic                            col_end;
   logic                            row_end;
   logic [MW-1:0]                   m_clamp;
   logic [MW-1:0]                   p_clamp;

   logic [EW-1:0]                   elem;
   logic [WW-1:0]                   wide;
   logic [WW-1:0]                   shifted;
   logic [BITS-1:0]                 quant;

   // ---------------------------------------------------------------------
   // Control decode
   // ---------------------------------------------------------------------
   assign start   = (state == S_IDLE) && mm_done;
   assign m_clamp = (m > DIM_M) ? DIM_M : m;
   assign p_clamp = (p > DIM_M) ? DIM_M : p;

   // Index comparisons run one bit wider than the indices so that a full
   // DIM-sized block (m_lat == DIM) compares correctly against DIM-1.
   assign col_end = ({1'b0, col} == (p_lat - MW'(1)));
   assign row_end = ({1'b0, row} == (m_lat - MW'(1)));

   assign out_valid  = (state == S_STREAM);
   assign out_last   = out_valid && row_end && col_end;
   assign out_row    = row;
   assign out_col    = col;
   assign busy       = (state == S_CAPTURE) || (state == S_STREAM);
   assign drain_done = (state == S_FINISH);

   // ---------------------------------------------------------------------
   // Capture buffer: contents are don't-care out of reset, so no reset
   // term; it only loads on an accepted mm_done from IDLE.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (start) begin
         cap_mem <= mm_data;
      end
   end

   // ---------------------------------------------------------------------
   // FSM, latched block geometry and stream indices
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         m_lat     <= '0;
         p_lat     <= '0;
         shift_lat <= '0;
         row       <= '0;
         col       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mm_done) begin
                  state     <= S_CAPTURE;
                  m_lat     <= m_clamp;
                  p_lat     <= p_clamp;
                  shift_lat <= shift;
                  row       <= '0;
                  col       <= '0;
               end
            end
            S_CAPTURE: begin
               // An empty block skips streaming but still reports completion.
               if ((m_lat == '0) || (p_lat == '0)) begin
                  state <= S_FINISH;
               end else begin
                  state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (out_ready) begin
                  if (col_end) begin
                     col <= '0;
                     if (row_end) begin
                        state <= S_FINISH;
                     end else begin
                        row <= row + IW'(1);
                     end
                  end else begin
                     col <= col + IW'(1);
                  end
               end
            end
            S_FINISH: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Sticky overrun: a result that arrives while we are still draining the
   // previous one is dropped, and software must learn about it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else if (mm_done && (state != S_IDLE)) begin
         overrun <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Requantization: purely combinational from the frozen buffer and the
   // registered indices, so the output is steady while the consumer stalls.
   // The datapath is one bit wider than the element so the rounding add
   // can never wrap.
   // ---------------------------------------------------------------------
   always_comb begin
      elem = cap_mem[row][col];
      wide = {1'b0, elem};
`ifdef MATMUL_DRAIN_ROUND_EN
      if (shift_lat != '0) begin
         wide = wide + (WW'(1) << (shift_lat - SHW'(1)));
      end
`endif
      shifted = wide >> shift_lat;
      if (int'(shift_lat) >= EW) begin
         quant = '0;
      end else if (|shifted[WW-1:BITS]) begin
         quant = '1;
      end else begin
         quant = shifted[BITS-1:0];
      end
   end

   assign out_data = out_valid ? quant : '0;

endmodule

// File: tb/tb_matmul_result_drain.sv
// tb/tb_matmul_result_drain.sv - scoreboard bench for matmul_result_drain
module tb_matmul_result_drain;

   localparam int BITS = 8;
   localparam int DIM  = 4;
   localparam int SHW  = 5;

   logic                               clk = 1'b0;
   logic                               rst_n;
   logic                               mm_done;
   logic [2:0]                         m;
   logic [2:0]                         p;
   logic [SHW-1:0]                     shift;
   logic [DIM-1:0][DIM-1:0][2*BITS-1:0] mm_data;
   logic                               out_valid;
   logic                               out_ready;
   logic [BITS-1:0]                    out_data;
   logic [1:0]                         out_row;
   logic [1:0]                         out_col;
   logic                               out_last;
   logic                               busy;
   logic                               drain_done;
   logic                               overrun;

   matmul_result_drain #(.BITS(BITS), .DIM(DIM), .SHW(SHW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mm_done    (mm_done),
      .m          (m),
      .p          (p),
      .shift      (shift),
      .mm_data    (mm_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_last   (out_last),
      .busy       (busy),
      .drain_done (drain_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] r;
      logic [1:0] c;
      logic       l;
   } beat_t;

   beat_t exp_q[$];
   int    n_pass     = 0;
   int    n_total    = 0;
   int    beats_seen = 0;
   beat_t held;
   logic  stalled = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   function automatic beat_t cur_beat();
      return {out_data, out_row, out_col, out_last};
   endfunction

   task automatic push(input logic [7:0] d, input int r, input int c, input logic l);
      exp_q.push_back({d, 2'(r), 2'(c), l});
   endtask

   // Monitor: pops the scoreboard on every accepted beat and checks that a
   // stalled beat stays put until it is taken.
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled <= 1'b0;
      end else begin
         if (stalled) begin
            check("valid_held", 32'(out_valid), 32'd1);
            if (out_valid) check("stall_hold", 32'(cur_beat()), 32'(held));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_beat: got 0x%0h, required no beat", cur_beat());
            end else begin
               check("beat", 32'(cur_beat()), 32'(exp_q.pop_front()));
               beats_seen++;
            end
         end
         stalled <= out_valid && !out_ready;
         held    <= cur_beat();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_block(input logic [2:0] mm, input logic [2:0] pp, input logic [SHW-1:0] sh);
      m       = mm;
      p       = pp;
      shift   = sh;
      mm_done = 1'b1;
      tick();
      mm_done = 1'b0;
   endtask

   task automatic wait_drain(input bit bp, input int limit);
      logic [3:0] pat = 4'b1001;
      bit seen = 1'b0;
      for (int cyc = 0; cyc < limit; cyc++) begin
         if (drain_done) begin
            seen = 1'b1;
            break;
         end
         if (bp) out_ready = pat[3 - (cyc % 4)];
         tick();
      end
      check("drain_done_seen", 32'(seen), 32'd1);
      out_ready = 1'b1;
      tick();
      check("drain_done_pulse", 32'(drain_done), 32'd0);
      check("idle_after_finish", 32'(busy), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [15:0] sat_val[4] = '{16'h1234, 16'h1234, 16'h1234, 16'h0018};
   logic [4:0]  sat_sh[4]  = '{5'd4, 5'd8, 5'd16, 5'd4};
`ifdef MATMUL_DRAIN_ROUND_EN
   logic [7:0]  sat_exp[4] = '{8'hFF, 8'h12, 8'h00, 8'h02};
`else
   logic [7:0]  sat_exp[4] = '{8'hFF, 8'h12, 8'h00, 8'h01};
`endif

   initial begin
      int b0;
      bit found;
      rst_n     = 1'b0;
      mm_done   = 1'b0;
      m         = '0;
      p         = '0;
      shift     = '0;
      mm_data   = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_drain_done", 32'(drain_done), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_indices", 32'({out_row, out_col}), 0);
      rst_n = 1'b1;
      tick();

      // Basic stream: 16*(4i+j) >> 4 = 4i+j
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) mm_data[i][j] = 16'(16 * (4 * i + j));
      for (int k = 0; k < 16; k++) push(8'(k), k / 4, k % 4, k == 15);
      b0 = beats_seen;
      start_block(3'd4, 3'd4, 5'd4);
      check("lat_capture_valid", 32'(out_valid), 0);
      check("lat_capture_busy", 32'(busy), 1);
      tick();
      check("lat_first_valid", 32'(out_valid), 1);
      check("lat_first_data", 32'(out_data), 0);
      found = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (out_valid && out_last) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("last_seen", 32'(found), 1);
      tick();
      check("basic_drain_done", 32'(drain_done), 1);
      check("basic_valid_dropped", 32'(out_valid), 0);
      wait_drain(1'b0, 10);
      check("basic_beats", 32'(beats_seen - b0), 16);

      // Saturation and shift
      for (int t = 0; t < 4; t++) begin
         mm_data = '0;
         mm_data[0][0] = sat_val[t];
         push(sat_exp[t], 0, 0, 1'b1);
         start_block(3'd1, 3'd1, sat_sh[t]);
         wait_drain(1'b0, 20);
      end

      // Sub-block 2x3 with backpressure, shift 0
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) mm_data[i][j] = 16'(8'hA0 + 4 * i + j);
      push(8'hA0, 0, 0, 0); push(8'hA1, 0, 1, 0); push(8'hA2, 0, 2, 0);
      push(8'hA4, 1, 0, 0); push(8'hA5, 1, 1, 0); push(8'hA6, 1, 2, 1);
      b0 = beats_seen;
      start_block(3'd2, 3'd3, 5'd0);
      wait_drain(1'b1, 60);
      check("sub_beats", 32'(beats_seen - b0), 6);

      // Degenerate m=0
      start_block(3'd0, 3'd4, 5'd0);
      check("empty_capture_done", 32'(drain_done), 0);
      check("empty_capture_busy", 32'(busy), 1);
      tick();
      check("empty_drain_done", 32'(drain_done), 1);
      check("empty_no_valid", 32'(out_valid), 0);
      tick();
      check("empty_done_pulse", 32'(drain_done), 0);

      // Clamp m=7 to 4 rows, p=2
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) mm_data[i][j] = 16'(16 * i + j + 1);
      push(8'h01, 0, 0, 0); push(8'h02, 0, 1, 0); push(8'h11, 1, 0, 0); push(8'h12, 1, 1, 0);
      push(8'h21, 2, 0, 0); push(8'h22, 2, 1, 0); push(8'h31, 3, 0, 0); push(8'h32, 3, 1, 1);
      start_block(3'd7, 3'd2, 5'd0);
      wait_drain(1'b0, 30);

      // Overrun during STREAM
      check("overrun_clear", 32'(overrun), 0);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) mm_data[i][j] = 16'(100 + 4 * i + j);
      push(8'd100, 0, 0, 0); push(8'd101, 0, 1, 0); push(8'd104, 1, 0, 0); push(8'd105, 1, 1, 1);
      start_block(3'd2, 3'd2, 5'd0);
      tick();
      mm_data = '1;
      start_block(3'd1, 3'd1, 5'd8);
      check("overrun_set", 32'(overrun), 1);
      wait_drain(1'b0, 20);
      repeat (3) tick();
      check("overrun_sticky", 32'(overrun), 1);
      mm_data = '0;
      mm_data[0][0] = 16'h0300;
      mm_data[0][1] = 16'h0040;
      push(8'hC0, 0, 0, 0); push(8'h10, 0, 1, 1);
      start_block(3'd1, 3'd2, 5'd2);
      wait_drain(1'b0, 20);
      check("overrun_still", 32'(overrun), 1);

      // Reset mid-stream after 5 beats
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) mm_data[i][j] = 16'(16 * (4 * i + j));
      for (int k = 0; k < 16; k++) push(8'(k), k / 4, k % 4, k == 15);
      b0 = beats_seen;
      start_block(3'd4, 3'd4, 5'd4);
      tick();
      repeat (5) tick();
      check("pre_reset_beats", 32'(beats_seen - b0), 5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_last", 32'(out_last), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_overrun", 32'(overrun), 0);
      exp_q.delete();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("post_rst_idle_valid", 32'(out_valid), 0);
      check("post_rst_idle_busy", 32'(busy), 0);
      mm_data = '0;
      mm_data[0][0] = 16'h0050;
      push(8'h05, 0, 0, 1);
      start_block(3'd1, 3'd1, 5'd4);
      wait_drain(1'b0, 20);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
